// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: default widths, port id
// encoding and the in-flight tag carried alongside the multiplier pipeline.
package mul_arbiter_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int MUL_LAT_DEF = 1;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_e;

    typedef struct packed {
        logic     vld;
        port_id_e id;
    } tag_t;

    // Converts a one-hot (or empty) grant into the id of the granted port.
    function automatic port_id_e grant_to_id(input logic [1:0] grant);
        return grant[1] ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/mul_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from eligibility plus the
// register remembering which port was granted last.
module mul_arbiter_rr_arb2
    import mul_arbiter_pkg::*;
(
    input  logic       mul_clk,
    input  logic       resetn,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    port_id_e last_grant;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        grant = 2'b00;
        unique case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == PORT0) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            last_grant <= PORT1;
        end else if (|grant) begin
            last_grant <= grant_to_id(grant);
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one pipelined multiplier between two requesters: round-robin issue,
// a tag pipeline alongside the multiplier, and per-port response registers.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic                mul_clk,
    input  logic                resetn,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic                req0_signed,
    input  logic [XLEN-1:0]     req0_x,
    input  logic [XLEN-1:0]     req0_y,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic                req1_signed,
    input  logic [XLEN-1:0]     req1_x,
    input  logic [XLEN-1:0]     req1_y,

    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [2*XLEN-1:0]   rsp0_result,

    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [2*XLEN-1:0]   rsp1_result,

    output logic                mul_signed,
    output logic [XLEN-1:0]     mul_x,
    output logic [XLEN-1:0]     mul_y,
    input  logic [2*XLEN-1:0]   mul_result
);

    logic [1:0]          req_valid;
    logic [1:0]          rsp_ready;
    logic [1:0]          elig;
    logic [1:0]          grant;
    logic [1:0]          busy;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_fire;
    logic [2*XLEN-1:0]   rsp_result [2];

    tag_t                tag_in;
    tag_t                tag_out;
    tag_t                tag_pipe [MUL_LAT];

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign rsp_fire  = rsp_valid & rsp_ready;

    // A port with an op outstanding stays ineligible until its response is taken.
    assign elig = req_valid & ~busy & {2{resetn}};

    mul_arbiter_rr_arb2 u_arb (
        .mul_clk (mul_clk),
        .resetn  (resetn),
        .elig    (elig),
        .grant   (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        mul_signed = 1'b0;
        mul_x      = '0;
        mul_y      = '0;
        tag_in     = '{vld: 1'b0, id: PORT0};
        if (grant[0]) begin
            mul_signed = req0_signed;
            mul_x      = req0_x;
            mul_y      = req0_y;
            tag_in     = '{vld: 1'b1, id: PORT0};
        end else if (grant[1]) begin
            mul_signed = req1_signed;
            mul_x      = req1_x;
            mul_y      = req1_y;
            tag_in     = '{vld: 1'b1, id: PORT1};
        end
    end

    // NOTE: the tag pipe is control state, not a data buffer, so every stage is
    // reset; a stale valid tag would otherwise claim a product after reset.
    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_out = tag_pipe[MUL_LAT-1];

    // Capture and handshake never coincide on one port: busy blocks reissue
    // until the previous product has been taken.
    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            busy      <= 2'b00;
            rsp_valid <= 2'b00;
            for (int p = 0; p < 2; p++) begin
                rsp_result[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (grant[p]) begin
                    busy[p] <= 1'b1;
                end else if (rsp_fire[p]) begin
                    busy[p] <= 1'b0;
                end

                if (tag_out.vld && tag_out.id == ((p == 0) ? PORT0 : PORT1)) begin
                    rsp_valid[p]  <= 1'b1;
                    rsp_result[p] <= mul_result;
                end else if (rsp_fire[p]) begin
                    rsp_valid[p]  <= 1'b0;
                end
            end
        end
    end

    assign rsp0_valid  = rsp_valid[0];
    assign rsp1_valid  = rsp_valid[1];
    assign rsp0_result = rsp_result[0];
    assign rsp1_result = rsp_result[1];

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios plus a randomized run
// against a port-level reference model; includes a one-cycle multiplier model.
module tb_mul_arbiter;

    logic        mul_clk;
    logic        resetn;
    logic [1:0]  req_valid;
    logic [1:0]  req_signed;
    logic [31:0] req_x [2];
    logic [31:0] req_y [2];
    logic [1:0]  rsp_ready;

    wire         req0_ready, req1_ready;
    wire         rsp0_valid, rsp1_valid;
    wire  [63:0] rsp0_result, rsp1_result;
    wire         mul_signed;
    wire  [31:0] mul_x, mul_y;
    logic [63:0] mul_result = '0;

    wire  [1:0]  req_r = {req1_ready, req0_ready};
    wire  [1:0]  rsp_v = {rsp1_valid, rsp0_valid};
    logic [63:0] rsp_r [2];
    assign rsp_r[0] = rsp0_result;
    assign rsp_r[1] = rsp1_result;

    int n_checks = 0;
    int n_fail   = 0;

    mul_arbiter dut (
        .mul_clk     (mul_clk),
        .resetn      (resetn),
        .req0_valid  (req_valid[0]),
        .req0_ready  (req0_ready),
        .req0_signed (req_signed[0]),
        .req0_x      (req_x[0]),
        .req0_y      (req_y[0]),
        .req1_valid  (req_valid[1]),
        .req1_ready  (req1_ready),
        .req1_signed (req_signed[1]),
        .req1_x      (req_x[1]),
        .req1_y      (req_y[1]),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp_ready[0]),
        .rsp0_result (rsp0_result),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp_ready[1]),
        .rsp1_result (rsp1_result),
        .mul_signed  (mul_signed),
        .mul_x       (mul_x),
        .mul_y       (mul_y),
        .mul_result  (mul_result)
    );

    initial begin
        mul_clk = 1'b0;
        forever #5 mul_clk = ~mul_clk;
    end

    function automatic logic [63:0] ref_product(input logic s, input logic [31:0] a,
                                                input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = s ? $signed({{32{a[31]}}, a}) : $signed({32'b0, a});
        sb = s ? $signed({{32{b[31]}}, b}) : $signed({32'b0, b});
        return 64'(sa * sb);
    endfunction

    // Multiplier with one cycle of latency, fed only by the arbiter's mul_* outputs.
    always @(posedge mul_clk) mul_result <= ref_product(mul_signed, mul_x, mul_y);

    task automatic step();
        @(posedge mul_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge mul_clk);
    endtask

    task automatic idle_inputs();
        req_valid  = 2'b00;
        req_signed = 2'b00;
        req_x[0] = '0; req_y[0] = '0;
        req_x[1] = '0; req_y[1] = '0;
        rsp_ready  = 2'b11;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        idle_inputs();
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        req_valid = 2'b11;
        req_x[0] = 32'h1111_2222; req_y[0] = 32'h3333_4444;
        req_x[1] = 32'h5555_6666; req_y[1] = 32'h7777_8888;
        step();
        sample();
        n_checks++; if (req_r !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b exp 00", req_r); end
        n_checks++; if (mul_x !== 32'h0 || mul_y !== 32'h0 || mul_signed !== 1'b0) begin
            n_fail++; $display("FAIL reset_mul_ops: got x=%h y=%h s=%b exp 0", mul_x, mul_y, mul_signed); end
        step();
        idle_inputs();
        resetn = 1'b1;
        sample();
        n_checks++; if (rsp_v !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 00", rsp_v); end
        n_checks++; if (rsp0_result !== 64'h0 || rsp1_result !== 64'h0) begin
            n_fail++; $display("FAIL reset_rsp_result: got %h %h exp 0", rsp0_result, rsp1_result); end
        n_checks++; if (mul_x !== 32'h0 || mul_y !== 32'h0 || mul_signed !== 1'b0) begin
            n_fail++; $display("FAIL idle_mul_ops: got x=%h y=%h s=%b exp 0", mul_x, mul_y, mul_signed); end
        step();
    endtask

    task automatic test_port0_unsigned();
        int lat;
        req_valid[0] = 1'b1; req_signed[0] = 1'b0;
        req_x[0] = 32'hFFFF_FFFF; req_y[0] = 32'd2;
        sample();
        n_checks++; if (req_r !== 2'b01) begin n_fail++; $display("FAIL p0_accept: got ready=%b exp 01", req_r); end
        n_checks++; if (mul_x !== 32'hFFFF_FFFF || mul_y !== 32'd2 || mul_signed !== 1'b0) begin
            n_fail++; $display("FAIL p0_issue_ops: got x=%h y=%h s=%b", mul_x, mul_y, mul_signed); end
        step();
        req_valid[0] = 1'b0;
        lat = 1;
        sample();
        while (!rsp0_valid && lat < 8) begin
            step(); sample(); lat++;
        end
        n_checks++; if (lat !== 2 || rsp0_valid !== 1'b1) begin
            n_fail++; $display("FAIL p0_latency: got %0d cycles valid=%b exp 2", lat, rsp0_valid); end
        n_checks++; if (rsp0_result !== 64'h0000_0001_FFFF_FFFE) begin
            n_fail++; $display("FAIL p0_result: got %h exp 00000001fffffffe", rsp0_result); end
        n_checks++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL p0_other_port: got rsp1_valid=%b exp 0", rsp1_valid); end
        step();
        sample();
        n_checks++; if (rsp0_valid !== 1'b0 || rsp0_result !== 64'h0000_0001_FFFF_FFFE) begin
            n_fail++; $display("FAIL p0_after_handshake: got valid=%b result=%h", rsp0_valid, rsp0_result); end
        step();
    endtask

    task automatic test_port1_signed();
        int lat;
        req_valid[1] = 1'b1; req_signed[1] = 1'b1;
        req_x[1] = 32'hFFFF_FFFF; req_y[1] = 32'd3;
        sample();
        n_checks++; if (req_r !== 2'b10) begin n_fail++; $display("FAIL p1_accept: got ready=%b exp 10", req_r); end
        n_checks++; if (mul_signed !== 1'b1 || mul_x !== 32'hFFFF_FFFF || mul_y !== 32'd3) begin
            n_fail++; $display("FAIL p1_issue_ops: got x=%h y=%h s=%b", mul_x, mul_y, mul_signed); end
        step();
        req_valid[1] = 1'b0;
        lat = 1;
        sample();
        while (!rsp1_valid && lat < 8) begin
            step(); sample(); lat++;
        end
        n_checks++; if (lat !== 2 || rsp1_result !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_fail++; $display("FAIL p1_result: got %h after %0d cycles exp fffffffffffffffd after 2", rsp1_result, lat); end
        n_checks++; if (rsp0_valid !== 1'b0 || rsp0_result !== 64'h0000_0001_FFFF_FFFE) begin
            n_fail++; $display("FAIL p1_port0_untouched: got valid=%b result=%h", rsp0_valid, rsp0_result); end
        step();
    endtask

    task automatic test_both_from_reset();
        apply_reset();
        req_valid = 2'b11;
        req_signed[0] = 1'b0; req_x[0] = 32'd7;          req_y[0] = 32'd9;
        req_signed[1] = 1'b1; req_x[1] = 32'hFFFF_FFFB; req_y[1] = 32'd6;
        sample();
        n_checks++; if (req_r !== 2'b01 || mul_x !== 32'd7) begin
            n_fail++; $display("FAIL both_first_grant: got ready=%b x=%h exp 01 x=7", req_r, mul_x); end
        step();
        req_valid[0] = 1'b0;
        sample();
        n_checks++; if (req_r !== 2'b10 || mul_x !== 32'hFFFF_FFFB || mul_signed !== 1'b1) begin
            n_fail++; $display("FAIL both_second_grant: got ready=%b x=%h s=%b", req_r, mul_x, mul_signed); end
        step();
        req_valid[1] = 1'b0;
        sample();
        n_checks++; if (rsp_v !== 2'b01 || rsp0_result !== 64'd63) begin
            n_fail++; $display("FAIL both_rsp0: got valid=%b result=%h exp 01 63", rsp_v, rsp0_result); end
        step();
        sample();
        n_checks++; if (rsp_v !== 2'b10 || rsp1_result !== 64'hFFFF_FFFF_FFFF_FFE2) begin
            n_fail++; $display("FAIL both_rsp1: got valid=%b result=%h exp 10 ffffffffffffffe2", rsp_v, rsp1_result); end
        step();
    endtask

    task automatic test_backpressure();
        logic [63:0] exp0, exp1;
        logic        pend1;
        int          last_acc, n_acc1;
        rsp_ready = 2'b10;
        req_valid = 2'b01;
        req_signed[0] = 1'b0; req_x[0] = 32'h1234_5678; req_y[0] = 32'h10;
        exp0 = 64'h0000_0001_2345_6780;
        pend1 = 1'b0; exp1 = '0; last_acc = -1; n_acc1 = 0;
        sample();
        n_checks++; if (req_r !== 2'b01) begin n_fail++; $display("FAIL bp_accept0: got ready=%b exp 01", req_r); end
        step();
        req_valid[1] = 1'b1; req_signed[1] = 1'($urandom_range(0, 1));
        req_x[1] = $urandom; req_y[1] = $urandom;
        for (int c = 1; c <= 12; c++) begin
            logic acc;
            sample();
            acc = req1_ready;
            n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req0_ready: cycle %0d got 1 exp 0", c); end
            if (c >= 2) begin
                n_checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== exp0) begin
                    n_fail++; $display("FAIL bp_rsp0_hold: cycle %0d got valid=%b result=%h exp 1 %h", c, rsp0_valid, rsp0_result, exp0); end
            end
            if (rsp1_valid) begin
                n_checks++; if (!pend1 || rsp1_result !== exp1) begin
                    n_fail++; $display("FAIL bp_rsp1: cycle %0d got %h exp %h pending=%b", c, rsp1_result, exp1, pend1); end
                pend1 = 1'b0;
            end
            if (acc) begin
                if (last_acc >= 0) begin
                    n_checks++; if (c - last_acc !== 3) begin
                        n_fail++; $display("FAIL bp_p1_spacing: got %0d cycles exp 3", c - last_acc); end
                end
                last_acc = c; n_acc1++;
                exp1 = ref_product(req_signed[1], req_x[1], req_y[1]); pend1 = 1'b1;
            end
            step();
            if (acc) begin
                req_signed[1] = 1'($urandom_range(0, 1)); req_x[1] = $urandom; req_y[1] = $urandom;
            end
        end
        n_checks++; if (n_acc1 !== 4 || pend1 !== 1'b0) begin
            n_fail++; $display("FAIL bp_p1_count: got %0d accepts pending=%b exp 4 0", n_acc1, pend1); end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        sample();
        n_checks++; if (rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp0_before_release: got 0 exp 1"); end
        step();
        sample();
        n_checks++; if (rsp0_valid !== 1'b0 || rsp0_result !== exp0) begin
            n_fail++; $display("FAIL bp_rsp0_release: got valid=%b result=%h exp 0 %h", rsp0_valid, rsp0_result, exp0); end
        step();
    endtask

    task automatic test_reset_mid_op();
        req_valid[0] = 1'b1; req_signed[0] = 1'b0;
        req_x[0] = 32'hDEAD_BEEF; req_y[0] = 32'd1;
        sample();
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_accept: got 0 exp 1"); end
        step();
        resetn = 1'b0;
        req_valid = 2'b11;
        sample();
        n_checks++; if (req_r !== 2'b00 || mul_x !== 32'h0) begin
            n_fail++; $display("FAIL rmid_in_reset: got ready=%b x=%h exp 00 0", req_r, mul_x); end
        step();
        resetn = 1'b1;
        req_valid = 2'b00;
        for (int c = 0; c < 5; c++) begin
            sample();
            n_checks++; if (rsp_v !== 2'b00 || rsp0_result !== 64'h0 || rsp1_result !== 64'h0) begin
                n_fail++; $display("FAIL rmid_dropped: cycle %0d got valid=%b r0=%h r1=%h exp 0", c, rsp_v, rsp0_result, rsp1_result); end
            step();
        end
        req_valid[0] = 1'b1; req_x[0] = 32'd5; req_y[0] = 32'd6;
        sample();
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_reaccept: got 0 exp 1"); end
        step();
        req_valid[0] = 1'b0;
        step();
        sample();
        n_checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== 64'd30) begin
            n_fail++; $display("FAIL rmid_next_op: got valid=%b result=%h exp 1 30", rsp0_valid, rsp0_result); end
        step();
    endtask

    task automatic test_random();
        logic        pend [2];
        logic [63:0] exp_val [2];
        logic [63:0] held [2];
        logic        prev_v [2];
        logic        prev_stall [2];
        int          acc_cyc [2];
        logic        last;
        logic [1:0]  exp_ready, elig;
        int          n_acc, n_rsp, drain;
        apply_reset();
        last = 1'b1; n_acc = 0; n_rsp = 0; drain = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; exp_val[p] = '0; held[p] = '0;
            prev_v[p] = 1'b0; prev_stall[p] = 1'b0; acc_cyc[p] = 0;
        end
        for (int cyc = 0; cyc < 60000; cyc++) begin
            if (n_acc >= 10000) begin
                if (drain == 8) break;
                drain++;
                req_valid = 2'b00; rsp_ready = 2'b11;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    req_valid[p]  = ($urandom_range(0, 99) < 70);
                    req_signed[p] = 1'($urandom_range(0, 1));
                    req_x[p] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                    req_y[p] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                    rsp_ready[p]  = ($urandom_range(0, 99) < 60);
                end
            end
            sample();
            elig = {req_valid[1] & ~pend[1], req_valid[0] & ~pend[0]};
            exp_ready[0] = elig[0] && (!elig[1] || last == 1'b1);
            exp_ready[1] = elig[1] && (!elig[0] || last == 1'b0);
            n_checks++; if (req_r !== exp_ready) begin
                n_fail++; $display("FAIL rnd_grant: cycle %0d got ready=%b exp %b", cyc, req_r, exp_ready); end
            for (int p = 0; p < 2; p++) begin
                if (rsp_v[p] && !prev_v[p]) begin
                    n_checks++; if (!pend[p] || cyc - acc_cyc[p] !== 2) begin
                        n_fail++; $display("FAIL rnd_latency%0d: got %0d cycles pending=%b exp 2", p, cyc - acc_cyc[p], pend[p]); end
                end
                if (prev_stall[p]) begin
                    n_checks++; if (rsp_v[p] !== 1'b1 || rsp_r[p] !== held[p]) begin
                        n_fail++; $display("FAIL rnd_hold%0d: got valid=%b result=%h exp 1 %h", p, rsp_v[p], rsp_r[p], held[p]); end
                end
                if (rsp_v[p] && rsp_ready[p]) begin
                    n_checks++; if (!pend[p] || rsp_r[p] !== exp_val[p]) begin
                        n_fail++; $display("FAIL rnd_result%0d: got %h exp %h pending=%b", p, rsp_r[p], exp_val[p], pend[p]); end
                    pend[p] = 1'b0; n_rsp++;
                end
                if (req_valid[p] && req_r[p]) begin
                    pend[p] = 1'b1; acc_cyc[p] = cyc; n_acc++;
                    exp_val[p] = ref_product(req_signed[p], req_x[p], req_y[p]);
                    last = (p == 1);
                end
                prev_v[p]     = rsp_v[p];
                prev_stall[p] = rsp_v[p] && !rsp_ready[p];
                held[p]       = rsp_r[p];
            end
            step();
        end
        n_checks++; if (n_acc < 10000 || n_rsp !== n_acc || pend[0] || pend[1]) begin
            n_fail++; $display("FAIL rnd_totals: got %0d accepts %0d responses pending=%b%b exp >=10000 equal none", n_acc, n_rsp, pend[1], pend[0]); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        idle_inputs();
        test_reset();
        test_port0_unsigned();
        test_port1_signed();
        test_both_from_reset();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
